// File: rtl/decode_stage_fwd_pkg.sv
// Shared opcode/func_3 encodings and immediate extraction helpers for the decode stage.
package decode_stage_fwd_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // Returns the immediate sign-extended to 32 bits; callers widen to XLEN.
  function automatic logic [31:0] imm_ext(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_fwd_branch.sv
// Branch/jump resolution in ID: condition evaluation and redirect target.
module decode_stage_fwd_branch
  import decode_stage_fwd_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      func_3,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    case (opcode)
      OPC_BRANCH: begin
        case (func_3)
          F3_BEQ:  taken = (op_a == op_b);
          F3_BNE:  taken = (op_a != op_b);
          F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
          F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
          F3_BLTU: taken = (op_a <  op_b);
          F3_BGEU: taken = (op_a >= op_b);
          default: taken = 1'b0;
        endcase
      end
      OPC_JAL:  taken = 1'b1;
      OPC_JALR: begin
        taken  = 1'b1;
        target = (op_a + imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// ID stage: decode, operand forwarding, hazard bubbles, branch resolution with
// wrong-path squash, and the registered ID/EX pipeline register.
module decode_stage_fwd
  import decode_stage_fwd_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [63:0] BOOT_ADDRESS = 64'h0,
  parameter int          SQUASH_SLOTS = 1,
  parameter bit          FWD_EN       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_id_valid,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic [31:0]     if_id_instr,
  output logic            id_ready,
  output logic [4:0]      rf_rs_1_num,
  output logic [4:0]      rf_rs_2_num,
  input  logic [XLEN-1:0] rf_rs_1,
  input  logic [XLEN-1:0] rf_rs_2,
  input  logic            ex_ready,
  input  logic            ex_mem_valid,
  input  logic            ex_mem_is_load,
  input  logic [4:0]      ex_mem_rd_num,
  input  logic [XLEN-1:0] ex_mem_val,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_num,
  input  logic [XLEN-1:0] wb_val,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs_1,
  output logic [XLEN-1:0] id_ex_rs_2,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd_num,
  output logic [6:0]      id_ex_opcode,
  output logic [6:0]      id_ex_func_7,
  output logic [2:0]      id_ex_func_3,
  output logic            id_ex_link,
  output logic            id_ex_illegal,
  output logic            b_taken,
  output logic [XLEN-1:0] b_pc
);

  localparam logic [1:0] SQUASH_INIT = 2'(SQUASH_SLOTS);

  logic [6:0]      opcode;
  logic [2:0]      func_3;
  logic [4:0]      rd_num;
  logic [1:0]      use_rs;
  logic            has_rd;
  logic            illegal;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs_num  [2];
  logic [XLEN-1:0] rf_data [2];
  logic [XLEN-1:0] rs_val  [2];
  logic [1:0]      opnd_hz;
  logic            is_br_jalr;
  logic            hazard;
  logic            squashing;
  logic            issue;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [1:0]      squash_cnt_reg;

  assign opcode      = if_id_instr[6:0];
  assign func_3      = if_id_instr[14:12];
  assign rs_num[0]   = if_id_instr[19:15];
  assign rs_num[1]   = if_id_instr[24:20];
  assign rf_rs_1_num = rs_num[0];
  assign rf_rs_2_num = rs_num[1];
  assign rf_data[0]  = rf_rs_1;
  assign rf_data[1]  = rf_rs_2;
  assign rd_num      = has_rd ? if_id_instr[11:7] : 5'd0;
  assign imm         = XLEN'(signed'(imm_ext(if_id_instr, fmt)));
  assign is_br_jalr  = (opcode == OPC_BRANCH) || (opcode == OPC_JALR);

  always_comb begin
    use_rs  = 2'b00;
    has_rd  = 1'b0;
    illegal = 1'b0;
    fmt     = IMM_I;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin has_rd = 1'b1; fmt = IMM_U; end
      OPC_JAL:            begin has_rd = 1'b1; fmt = IMM_J; end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        has_rd = 1'b1; use_rs = 2'b01;
      end
      OPC_BRANCH:         begin use_rs = 2'b11; fmt = IMM_B; end
      OPC_STORE:          begin use_rs = 2'b11; fmt = IMM_S; end
      OPC_OP:             begin use_rs = 2'b11; has_rd = 1'b1; end
      OPC_MISC_MEM:       ;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin has_rd = 1'b1; use_rs = 2'b01; end
        else illegal = 1'b1;
      end
      OPC_OP_32: begin
        if (XLEN == 64) begin has_rd = 1'b1; use_rs = 2'b11; end
        else illegal = 1'b1;
      end
      default:            illegal = 1'b1;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic em_hit, wb_hit, load_use, br_dep, no_fwd;
    assign em_hit = ex_mem_valid && (ex_mem_rd_num != 5'd0) && (ex_mem_rd_num == rs_num[gi]);
    assign wb_hit = wb_valid && (wb_rd_num != 5'd0) && (wb_rd_num == rs_num[gi]);
    assign rs_val[gi] = (rs_num[gi] == 5'd0)                  ? '0 :
                        (FWD_EN && em_hit && !ex_mem_is_load) ? ex_mem_val :
                        (FWD_EN && wb_hit)                    ? wb_val :
                                                                rf_data[gi];
    assign load_use = id_ex_valid && (id_ex_opcode == OPC_LOAD) &&
                      (id_ex_rd_num != 5'd0) && (id_ex_rd_num == rs_num[gi]);
    // Branches resolve here, so even a one-cycle-old ALU result is too late.
    assign br_dep   = is_br_jalr &&
                      ((id_ex_valid && (id_ex_rd_num != 5'd0) && (id_ex_rd_num == rs_num[gi])) ||
                       (em_hit && ex_mem_is_load));
    assign no_fwd   = !FWD_EN && (em_hit || wb_hit);
    assign opnd_hz[gi] = use_rs[gi] && (load_use || br_dep || no_fwd);
  end

  assign hazard    = if_id_valid && (opnd_hz != 2'b00);
  assign id_ready  = if_id_valid && ex_ready && !hazard && !flush;
  assign squashing = (squash_cnt_reg != 2'd0);
  assign issue     = id_ready && !squashing;

  decode_stage_fwd_branch #(.XLEN(XLEN)) u_branch (
    .op_a   (rs_val[0]),
    .op_b   (rs_val[1]),
    .func_3 (func_3),
    .opcode (opcode),
    .pc     (if_id_pc),
    .imm    (imm),
    .taken  (br_taken),
    .target (br_target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs_1     <= '0;
      id_ex_rs_2     <= '0;
      id_ex_imm      <= '0;
      id_ex_rd_num   <= '0;
      id_ex_opcode   <= '0;
      id_ex_func_7   <= '0;
      id_ex_func_3   <= '0;
      id_ex_link     <= 1'b0;
      id_ex_illegal  <= 1'b0;
      b_taken        <= 1'b0;
      b_pc           <= BOOT_ADDRESS[XLEN-1:0];
      squash_cnt_reg <= 2'd0;
    end else if (flush) begin
      id_ex_valid    <= 1'b0;
      b_taken        <= 1'b0;
      squash_cnt_reg <= 2'd0;
    end else begin
      b_taken <= 1'b0;
      if (ex_ready) begin
        if (issue) begin
          id_ex_valid   <= 1'b1;
          id_ex_pc      <= if_id_pc;
          id_ex_rs_1    <= rs_val[0];
          id_ex_rs_2    <= rs_val[1];
          id_ex_imm     <= imm;
          id_ex_rd_num  <= rd_num;
          id_ex_opcode  <= opcode;
          id_ex_func_7  <= if_id_instr[31:25];
          id_ex_func_3  <= func_3;
          id_ex_link    <= (opcode == OPC_JAL) || (opcode == OPC_JALR);
          id_ex_illegal <= illegal;
          if (br_taken) begin
            b_taken        <= 1'b1;
            b_pc           <= br_target;
            squash_cnt_reg <= SQUASH_INIT;
          end
        end else begin
          id_ex_valid <= 1'b0;
          // An accepted slot while squashing is the wrong-path fetch being dropped.
          if (id_ready && squashing)
            squash_cnt_reg <= squash_cnt_reg - 2'd1;
        end
      end
    end
  end

endmodule
